// File: rtl/mem_port_arbiter_if.sv
// Request, response and memory-port bundle of mem_port_arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic                  req0_we;
  logic                  req1_we;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req0_ready;
  logic                  req1_ready;
  logic                  rsp0_valid;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_sel;

  modport slave (
    input  req0_valid, req1_valid, req0_addr, req1_addr, req0_we, req1_we,
           req0_wdata, req1_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
           mem_req, mem_addr, mem_we, mem_wdata, mem_sel
  );

  modport master (
    output req0_valid, req1_valid, req0_addr, req1_addr, req0_we, req1_we,
           req0_wdata, req1_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, rsp_err,
           mem_req, mem_addr, mem_we, mem_wdata, mem_sel
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (req0) and LSU (req1).
// Optional response watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic                  sel;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp0_q;
  logic                  rsp1_q;

  logic                  win_valid;
  logic                  winner;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  win_we;
  logic [DATA_WIDTH-1:0] win_wdata;

  // Winner selection: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    win_valid = 1'b0;
    winner    = 1'b0;
    if (state == IDLE) begin
      case ({bus.req1_valid, bus.req0_valid})
        2'b01:   begin win_valid = 1'b1; winner = 1'b0;        end
        2'b10:   begin win_valid = 1'b1; winner = 1'b1;        end
        2'b11:   begin win_valid = 1'b1; winner = ~last_grant; end
        default: begin win_valid = 1'b0; winner = 1'b0;        end
      endcase
    end
    win_addr  = winner ? bus.req1_addr  : bus.req0_addr;
    win_we    = winner ? bus.req1_we    : bus.req0_we;
    win_wdata = winner ? bus.req1_wdata : bus.req0_wdata;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             rsp_err_q;
  logic             timeout;

  // Fires on the cycle the count would reach the limit without a response.
  assign timeout = ((state == ISSUE) || ((state == WAIT) && !bus.mem_rvalid)) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      sel         <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      if (state != IDLE) cnt_q <= cnt_q + CNT_W'(1);
`endif
      case (state)
        IDLE: begin
          if (win_valid) begin
            mem_addr_q  <= win_addr;
            mem_we_q    <= win_we;
            mem_wdata_q <= win_wdata;
            sel         <= winner;
            last_grant  <= winner;
            mem_req_q   <= 1'b1;
            state       <= ISSUE;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        ISSUE: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            rsp_rdata_q <= bus.mem_rdata;
            rsp0_q      <= ~sel;
            rsp1_q      <= sel;
            state       <= IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
`ifdef MEM_ARB_TIMEOUT_EN
      // Abandon the transaction; any later rvalid lands in IDLE and is dropped.
      if (timeout) begin
        state       <= IDLE;
        mem_req_q   <= 1'b0;
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
        rsp0_q      <= ~sel;
        rsp1_q      <= sel;
      end
`endif
    end
  end

  assign bus.req0_ready = ~rst & win_valid & ~winner;
  assign bus.req1_ready = ~rst & win_valid & winner;
  assign bus.rsp0_valid = rsp0_q;
  assign bus.rsp1_valid = rsp1_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_sel    = sel;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.rsp_err    = rsp_err_q;
`else
  assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model, per-cycle
// compare, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } txn_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return (a == 32'h100) ? 32'hDEAD_BEEF : {lo, 16'hC0DE};
  endfunction

  function automatic int pick(input logic v0, input logic v1, input logic last);
    if (v0 === 1'b1 && v1 === 1'b1) return last ? 0 : 1;
    if (v0 === 1'b1) return 0;
    if (v1 === 1'b1) return 1;
    return -1;
  endfunction

  // Requesters: present the queue head until a handshake is seen.
  txn_t q0[$];
  txn_t q1[$];
  logic hs0 = 1'b0;
  logic hs1 = 1'b0;
  always @(posedge clk) begin
    #1;
    if (hs0) q0.delete(0);
    if (hs1) q1.delete(0);
    bus.req0_valid = (q0.size() != 0) && !rst;
    bus.req1_valid = (q1.size() != 0) && !rst;
    bus.req0_addr  = (q0.size() != 0) ? q0[0].addr  : '0;
    bus.req0_we    = (q0.size() != 0) ? q0[0].we    : 1'b0;
    bus.req0_wdata = (q0.size() != 0) ? q0[0].wdata : '0;
    bus.req1_addr  = (q1.size() != 0) ? q1[0].addr  : '0;
    bus.req1_we    = (q1.size() != 0) ? q1[0].we    : 1'b0;
    bus.req1_wdata = (q1.size() != 0) ? q1[0].wdata : '0;
  end

  // Memory: grant after gnt_wait stalled cycles, respond rv_delay+1 cycles later.
  int            gnt_wait = 0;
  int            gnt_cnt  = 0;
  int            rv_delay = 0;
  int            rv_due   = 0;
  bit            rsp_en   = 1'b1;
  bit            late_rv  = 1'b0;
  logic [AW-1:0] rv_addr  = '0;
  always @(negedge clk) begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_gnt    = 1'b0;
    if (late_rv) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h0BAD_F00D;
      late_rv        = 1'b0;
    end else if (rv_due > 0) begin
      rv_due--;
      if (rv_due == 0 && rsp_en) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_data(rv_addr);
      end
    end
    if (bus.mem_req === 1'b1) begin
      if (gnt_cnt < gnt_wait) gnt_cnt++;
      else begin
        bus.mem_gnt = 1'b1;
        gnt_cnt     = 0;
        rv_due      = rv_delay + 1;
        rv_addr     = bus.mem_addr;
      end
    end
  end

  // Transaction-level model of the expected outputs.
  bit            live = 1'b0;
  bit            m_out, m_gnt;
  int            m_age;
  logic          m_last, m_sel, m_req, m_we, m_err, m_rsp0, m_rsp1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  int            grant_log[$];

  always @(posedge clk) begin
    int w;
    bit done;
    live = 1'b1;
    if (rst) begin
      m_out = 0; m_gnt = 0; m_age = 0;
      m_last = 1'b1; m_sel = 1'b0; m_req = 1'b0; m_we = 1'b0; m_err = 1'b0;
      m_rsp0 = 1'b0; m_rsp1 = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      m_rsp0 = 1'b0;
      m_rsp1 = 1'b0;
      done   = 1'b0;
      if (!m_out) begin
        w = pick(bus.req0_valid, bus.req1_valid, m_last);
        if (w >= 0) begin
          m_addr  = (w == 1) ? bus.req1_addr  : bus.req0_addr;
          m_we    = (w == 1) ? bus.req1_we    : bus.req0_we;
          m_wdata = (w == 1) ? bus.req1_wdata : bus.req0_wdata;
          m_sel   = (w == 1);
          m_last  = (w == 1);
          m_out   = 1; m_gnt = 0; m_age = 0; m_req = 1'b1;
          grant_log.push_back(w);
        end
      end else begin
        m_age++;
        if (!m_gnt) begin
          if (bus.mem_gnt === 1'b1) begin m_gnt = 1; m_req = 1'b0; end
        end else if (bus.mem_rvalid === 1'b1) begin
          m_rdata = bus.mem_rdata; m_err = 1'b0;
          m_rsp0 = !m_sel; m_rsp1 = m_sel; m_out = 0; done = 1'b1;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        if (!done && m_age == int'(TMO)) begin
          m_rdata = '0; m_err = 1'b1; m_req = 1'b0;
          m_rsp0 = !m_sel; m_rsp1 = m_sel; m_out = 0;
        end
`endif
      end
    end
  end

  // Per-cycle compare plus handshake/response bookkeeping.
  int n_rsp0 = 0;
  int n_rsp1 = 0;
  int obs[$];
  always @(negedge clk) begin
    int w;
    #1;
    if (live) begin
      w = (rst || m_out) ? -1 : pick(bus.req0_valid, bus.req1_valid, m_last);
      chk("req0_ready", bus.req0_ready, w == 0);
      chk("req1_ready", bus.req1_ready, w == 1);
      chk("rsp0_valid", bus.rsp0_valid, m_rsp0);
      chk("rsp1_valid", bus.rsp1_valid, m_rsp1);
      chk("rsp_rdata",  bus.rsp_rdata,  m_rdata);
      chk("rsp_err",    bus.rsp_err,    m_err);
      chk("mem_req",    bus.mem_req,    m_req);
      chk("mem_addr",   bus.mem_addr,   m_addr);
      chk("mem_we",     bus.mem_we,     m_we);
      chk("mem_wdata",  bus.mem_wdata,  m_wdata);
      chk("mem_sel",    bus.mem_sel,    m_sel);
    end
    hs0 = (bus.req0_valid === 1'b1) && (bus.req0_ready === 1'b1);
    hs1 = (bus.req1_valid === 1'b1) && (bus.req1_ready === 1'b1);
    if (hs0) obs.push_back(0);
    if (hs1) obs.push_back(1);
    if (bus.rsp0_valid === 1'b1) n_rsp0++;
    if (bus.rsp1_valid === 1'b1) n_rsp1++;
  end

  task automatic wait_hs(input int port, input int max, output int ok);
    ok = 0;
    for (int i = 0; i < max && ok == 0; i++) begin
      @(negedge clk);
      if (port == 0) ok = (bus.req0_valid === 1'b1 && bus.req0_ready === 1'b1) ? 1 : 0;
      else           ok = (bus.req1_valid === 1'b1 && bus.req1_ready === 1'b1) ? 1 : 0;
    end
  endtask

  task automatic wait_rsp(input int a, input int b, input int max, output int ok);
    ok = 0;
    for (int i = 0; i < max && ok == 0; i++) begin
      @(negedge clk);
      ok = (n_rsp0 >= a && n_rsp1 >= b) ? 1 : 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int ok;
    int c0, c1;
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mem_req",   bus.mem_req,    0);
    chk("rst_mem_sel",   bus.mem_sel,    0);
    chk("rst_rsp_rdata", bus.rsp_rdata,  0);
    chk("rst_rsp0",      bus.rsp0_valid, 0);
    rst = 1'b0;

    // req0 read of 0x100, zero-wait memory
    q0.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
    wait_hs(0, 20, ok);
    chk("t1_accept", ok, 1);
    @(negedge clk);
    chk("t1_mem_req",  bus.mem_req,  1);
    chk("t1_mem_addr", bus.mem_addr, 32'h100);
    chk("t1_mem_sel",  bus.mem_sel,  0);
    @(negedge clk);
    chk("t1_wait_req", bus.mem_req, 0);
    @(negedge clk);
    chk("t1_rsp0",  bus.rsp0_valid, 1);
    chk("t1_rdata", bus.rsp_rdata,  32'hDEAD_BEEF);

    // Both requesters busy: grants alternate starting with req0
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    obs.delete(); grant_log.delete();
    c0 = n_rsp0; c1 = n_rsp1;
    for (int i = 0; i < 2; i++) begin
      q0.push_back('{addr: AW'(32'h1000 + i * 4), we: 1'b0, wdata: 32'h0});
      q1.push_back('{addr: AW'(32'h2000 + i * 4), we: 1'b1, wdata: DW'(32'hA000 + i)});
    end
    wait_rsp(c0 + 2, c1 + 2, 60, ok);
    chk("t2_done", ok, 1);
    repeat (2) @(negedge clk);
    chk("t2_rsp0_cnt", n_rsp0 - c0, 2);
    chk("t2_rsp1_cnt", n_rsp1 - c1, 2);
    chk("t2_obs_n", obs.size(), 4);
    chk("t2_log_n", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_obs_order", (i < obs.size()) ? obs[i] : 9, exp_order[i]);
      chk("t2_log_order", (i < grant_log.size()) ? grant_log[i] : 9, exp_order[i]);
    end

    // req1 write with memory stalling grant for 3 cycles
    gnt_wait = 3;
    c1 = n_rsp1;
    q1.push_back('{addr: 32'h200, we: 1'b1, wdata: 32'h1234_5678});
    wait_hs(1, 20, ok);
    chk("t3_accept", ok, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_req",   bus.mem_req,   1);
      chk("t3_hold_addr",  bus.mem_addr,  32'h200);
      chk("t3_hold_we",    bus.mem_we,    1);
      chk("t3_hold_wdata", bus.mem_wdata, 32'h1234_5678);
    end
    wait_rsp(n_rsp0, c1 + 1, 20, ok);
    chk("t3_done", ok, 1);
    repeat (3) @(negedge clk);
    chk("t3_rsp1_once", n_rsp1 - c1, 1);
    gnt_wait = 0;

    // Reset while in WAIT; rvalid arrives the cycle after reset
    rv_delay = 1;
    c0 = n_rsp0; c1 = n_rsp1;
    q0.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0});
    wait_hs(0, 20, ok);
    chk("t4_accept", ok, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_in_wait", bus.mem_req, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_rst_sel",   bus.mem_sel,   0);
    chk("t4_rst_addr",  bus.mem_addr,  0);
    chk("t4_rst_rdata", bus.rsp_rdata, 0);
    @(negedge clk);
    chk("t4_no_rsp0", bus.rsp0_valid, 0);
    chk("t4_no_rsp1", bus.rsp1_valid, 0);
    repeat (2) @(negedge clk);
    chk("t4_rsp_cnt", (n_rsp0 - c0) + (n_rsp1 - c1), 0);
    rv_delay = 0;
    obs.delete();
    q0.push_back('{addr: 32'h44, we: 1'b0, wdata: 32'h0});
    q1.push_back('{addr: 32'h48, we: 1'b0, wdata: 32'h0});
    wait_rsp(c0 + 1, c1 + 1, 40, ok);
    chk("t4_done", ok, 1);
    chk("t4_first_grant", (obs.size() > 0) ? obs[0] : 9, 0);

    // Back-to-back: req0 accepted in the rsp1_valid cycle
    repeat (2) @(negedge clk);
    q1.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0});
    wait_hs(1, 20, ok);
    chk("t5_accept1", ok, 1);
    @(negedge clk);
    @(negedge clk);
    q0.push_back('{addr: 32'h104, we: 1'b0, wdata: 32'h0});
    @(negedge clk);
    chk("t5_rsp1",     bus.rsp1_valid, 1);
    chk("t5_rdy0",     bus.req0_ready, 1);
    chk("t5_sel_hold", bus.mem_sel,    1);
    @(negedge clk);
    chk("t5_mem_req", bus.mem_req,  1);
    chk("t5_sel_new", bus.mem_sel,  0);
    chk("t5_addr",    bus.mem_addr, 32'h104);
    @(negedge clk);
    @(negedge clk);
    chk("t5_rsp0",  bus.rsp0_valid, 1);
    chk("t5_rdata", bus.rsp_rdata,  32'h0104_C0DE);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: memory never answers
    repeat (2) @(negedge clk);
    rsp_en = 1'b0;
    c0 = n_rsp0;
    q0.push_back('{addr: 32'h500, we: 1'b0, wdata: 32'h0});
    wait_hs(0, 20, ok);
    chk("t6_accept", ok, 1);
    for (int i = 0; i < int'(TMO); i++) begin
      @(negedge clk);
      chk("t6_no_early_rsp", bus.rsp0_valid, 0);
    end
    @(negedge clk);
    chk("t6_rsp0",  bus.rsp0_valid, 1);
    chk("t6_err",   bus.rsp_err,    1);
    chk("t6_rdata", bus.rsp_rdata,  0);
    late_rv = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_late_ignored", n_rsp0 - c0, 1);
    rsp_en = 1'b1;
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: instruction fetch (req0) and load/store unit (req1).
- Round-robin arbitration with one outstanding transaction at a time.
- Captures the winner's request, drives the memory port, routes the response back to the owner.
- Exports mem_sel, which drives the select of the port's address/data mux.

Parameters:
ADDR_WIDTH, 32, byte address width of requests and memory port
DATA_WIDTH, 32, read/write data width
TIMEOUT_CYCLES, 64, response watchdog limit in cycles; used only with MEM_ARB_TIMEOUT_EN

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
req0_valid/req1_valid  input  1  request pending; held with fields stable until reqN_ready
req0_addr/req1_addr  input  ADDR_WIDTH  request address
req0_we/req1_we  input  1  1=write, 0=read
req0_wdata/req1_wdata  input  DATA_WIDTH  write data
req0_ready/req1_ready  output  1  request accepted this cycle
rsp0_valid/rsp1_valid  output  1  one-cycle response pulse to owner
rsp_rdata  output  DATA_WIDTH  response read data; valid with rspN_valid; shared by both requesters
rsp_err  output  1  response error flag; valid with rspN_valid
mem_req  output  1  memory request strobe
mem_addr  output  ADDR_WIDTH  registered address
mem_we  output  1  registered write enable
mem_wdata  output  DATA_WIDTH  registered write data
mem_gnt  input  1  memory accepts request this cycle
mem_rvalid  input  1  memory response; sent for both reads and writes
mem_rdata  input  DATA_WIDTH  memory read data
mem_sel  output  1  current owner: 0=req0, 1=req1

Behaviour:
- Clocking and reset:
  - One clock. rst is synchronous and active-high, sampled on the rising edge of clk.
  - Reset values: state=IDLE; all ready, rsp and mem_req outputs 0; mem_addr, mem_wdata, rsp_rdata = 0; mem_we=0; mem_sel=0; rsp_err=0.
  - last_grant resets to 1, so req0 wins the first contest.
- State machine: IDLE, ISSUE, WAIT.
- IDLE:
  - Winner is computed combinationally.
  - If exactly one reqN_valid=1, that requester wins.
  - If both are valid, the requester != last_grant wins.
  - reqN_ready=1 for the winner only, same cycle; ready is never asserted outside IDLE.
  - On acceptance: register addr/we/wdata into the mem_* outputs, set mem_sel=winner, set last_grant=winner, go to ISSUE.
- ISSUE:
  - mem_req=1 with fields stable until mem_gnt=1, then go to WAIT.
  - mem_rvalid in the same cycle as mem_gnt is not supported; memory returns rvalid at least one cycle after gnt.
- WAIT:
  - mem_req=0.
  - On mem_rvalid=1: register mem_rdata into rsp_rdata, set rsp_err=0, go to IDLE.
  - Next cycle: rsp{mem_sel}_valid=1 for exactly one cycle.
- Back-to-back: IDLE may accept a new request in the same cycle a response pulse is presented.
- Minimum latency:
  - accept at T, mem_req at T+1 (gnt same cycle), rvalid at T+2, rsp pulse and IDLE at T+3.
  - Minimum 3 cycles per transaction.
- mem_sel holds its value in IDLE; it changes only on acceptance.
- Unexpected mem_rvalid in IDLE or ISSUE is ignored.
- Reset mid-operation: the transaction is dropped, no response pulse is issued, all registers return to reset values.
- A requester deasserting valid before ready is a protocol violation; the behaviour is undefined.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - Cycle counter of width $clog2(TIMEOUT_CYCLES+1), cleared on entry to ISSUE and incremented each cycle in ISSUE or WAIT.
  - When the count reaches TIMEOUT_CYCLES with no rvalid, go to IDLE.
  - Next cycle: owner's rsp pulse with rsp_err=1 and rsp_rdata=0.
  - A late mem_rvalid arriving afterwards is ignored.
- Not defined: no counter; the arbiter waits indefinitely in ISSUE/WAIT; rsp_err is tied 0.

Test Plan:
- Reset, then req0 alone reads addr 0x100; memory gives gnt at once, rvalid next cycle with 0xDEADBEEF -> req0_ready at T, mem_req T+1, rsp0_valid at T+3 with rsp_rdata=0xDEADBEEF; mem_sel=0.
- Both valid continuously for 4 transactions -> grants alternate req0, req1, req0, req1; mem_sel follows the grant; no responses are misrouted.
- req1 write addr 0x200 data 0x12345678, memory holds mem_gnt low 3 cycles -> mem_req and fields stay stable all 3 cycles; rsp1_valid pulses once after rvalid.
- rst asserted during WAIT, rvalid arrives the cycle after -> no rsp pulse; all outputs at reset values; next contest with both valid grants req0.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never gives rvalid -> rsp0_valid with rsp_err=1 once the count reaches 8; a later rvalid is ignored.
- req0 accepted in the same cycle as rsp1_valid (back-to-back) -> req0 transaction proceeds with normal latency; mem_sel switches to 0 on acceptance.
